// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared definitions for push-button conditioning: the
//                debounce state encoding and the default timing constants
//                from which the stability window is derived.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

   // Default board timing: 1 ms stability window at 50 MHz.
   localparam int CLK_HZ            = 50_000_000;
   localparam int DEBOUNCE_MS       = 1;
   localparam int DEF_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEF_CNT_WIDTH     = 16;
   localparam int DEF_SYNC_STAGES   = 2;

   // Debounce FSM encoding, 2 bits.
   typedef enum logic [1:0] {
      RELEASED       = 2'd0,
      ARMING_PRESS   = 2'd1,
      PRESSED        = 2'd2,
      ARMING_RELEASE = 2'd3
   } state_e;

endpackage : button_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-stage flop synchronizer for an asynchronous board
//                input. All stages reset to RESET_VAL, which is 1 for the
//                active-low board inputs so that reset looks "released".
//  Ports       : clk      - system clock (rising edge)
//                rst_n    - synchronous active-low reset
//                async_in - asynchronous input pin
//                sync_out - output of the last synchronizer stage
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift toward the MSB; bit 0 is the metastability-exposed stage.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Synchronizes and debounces an active-low push button.
//                A new pin level must persist for STABLE_CYCLES synchronized
//                cycles before it is accepted. Publishes a clean level,
//                single-cycle press/release strobes and a 3-bit wrapping
//                press counter that drives the board LEDs.
//  Ports       : clk           - system clock (rising edge)
//                rst_n         - synchronous active-low reset
//                btn_n_raw     - raw button pin, 0 = pressed, asynchronous
//                btn_level     - debounced level, 1 = pressed
//                press_pulse   - one-cycle strobe on an accepted press
//                release_pulse - one-cycle strobe on an accepted release
//                press_count   - accepted presses modulo 8 (LED[2:0])
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
   import button_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n_raw,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic [2:0] press_count
);

   // Terminal count: the entry cycle already counts as 1, so acceptance
   // happens when the counter reaches STABLE_CYCLES-1 with the pin unchanged.
   localparam logic [CNT_WIDTH-1:0] C_LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);

   logic                 sync_n;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 btn_level_q, btn_level_d;
   logic                 press_pulse_q, press_pulse_d;
   logic                 release_pulse_q, release_pulse_d;
   logic [2:0]           press_count_q, press_count_d;

   sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (btn_n_raw),
      .sync_out (sync_n)
   );

   // Next-state logic. The counter defaults to 0 so that every exit from an
   // arming state (bounce or acceptance) discards the partial count.
   always_comb begin
      state_d         = state_q;
      cnt_d           = '0;
      btn_level_d     = btn_level_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      press_count_d   = press_count_q;

      case (state_q)
         RELEASED: begin
            if (!sync_n) begin
               state_d = ARMING_PRESS;
               cnt_d   = C_ONE;
            end
         end

         ARMING_PRESS: begin
            if (sync_n) begin
               state_d = RELEASED;
            end else if (cnt_q == C_LAST_CNT) begin
               state_d       = PRESSED;
               press_pulse_d = 1'b1;
               btn_level_d   = 1'b1;
               press_count_d = press_count_q + 3'd1;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end

         PRESSED: begin
            if (sync_n) begin
               state_d = ARMING_RELEASE;
               cnt_d   = C_ONE;
            end
         end

         ARMING_RELEASE: begin
            if (!sync_n) begin
               state_d = PRESSED;
            end else if (cnt_q == C_LAST_CNT) begin
               state_d         = RELEASED;
               release_pulse_d = 1'b1;
               btn_level_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end

         default: begin
            state_d = RELEASED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= RELEASED;
         cnt_q           <= '0;
         btn_level_q     <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         press_count_q   <= 3'd0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         btn_level_q     <= btn_level_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         press_count_q   <= press_count_d;
      end
   end

   assign btn_level     = btn_level_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign press_count   = press_count_q;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Directed self-checking bench for button_debounce with
//                STABLE_CYCLES=4, SYNC_STAGES=2. Edge numbering: edge 0 is
//                the first rising edge that samples a new pin level; with
//                these parameters an accepted event is registered at edge 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

   logic       clk;
   logic       rst_n;
   logic       btn_n_raw;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic [2:0] press_count;

   int errors     = 0;
   int checks     = 0;
   int press_seen = 0;
   int rel_seen   = 0;

   button_debounce #(
      .STABLE_CYCLES (4),
      .CNT_WIDTH     (16),
      .SYNC_STAGES   (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_n_raw     (btn_n_raw),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .press_count   (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run n edges; the press/release strobe must be high only at edge p_at/r_at
   // (use -1 for "never").
   task automatic watch(input int n, input int p_at, input int r_at, input string tag);
      for (int k = 0; k < n; k++) begin
         tick();
         if (press_pulse === 1'b1)   press_seen++;
         if (release_pulse === 1'b1) rel_seen++;
         check({tag, "_press_pulse"},   8'(press_pulse),   8'(k == p_at));
         check({tag, "_release_pulse"}, 8'(release_pulse), 8'(k == r_at));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"},   8'(btn_level),     8'h00);
      check({tag, "_press"},   8'(press_pulse),   8'h00);
      check({tag, "_release"}, 8'(release_pulse), 8'h00);
      check({tag, "_count"},   8'(press_count),   8'h00);
   endtask

   logic bounce_v [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      rst_n     = 1'b0;
      btn_n_raw = 1'b0;

      // ---- Reset with the pin held low -----------------------------------
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all_zero("reset_hold");
      end
      rst_n = 1'b1;
      watch(8, 5, -1, "rst_press");
      check("rst_press_count", 8'(press_count), 8'd1);
      check("rst_press_level", 8'(btn_level),   8'd1);
      btn_n_raw = 1'b1;
      watch(8, -1, 5, "rst_release");
      check("rst_release_level", 8'(btn_level), 8'd0);

      // ---- Clean press / release from a fresh reset ----------------------
      rst_n = 1'b0;
      tick();
      check_all_zero("reset2");
      rst_n     = 1'b1;
      btn_n_raw = 1'b0;
      watch(10, 5, -1, "clean_press");
      check("clean_level_high", 8'(btn_level),   8'd1);
      check("clean_count",      8'(press_count), 8'd1);
      btn_n_raw = 1'b1;
      watch(4, -1, -1, "clean_rel_early");
      check("clean_level_held", 8'(btn_level), 8'd1);
      watch(6, -1, 1, "clean_rel_late");
      check("clean_level_low", 8'(btn_level),   8'd0);
      check("clean_count_kept", 8'(press_count), 8'd1);

      // ---- Bounce: only the final 4-sample run is accepted ---------------
      press_seen = 0;
      for (int i = 0; i < 14; i++) begin
         if (i < 10) btn_n_raw = bounce_v[i];
         tick();
         if (press_pulse === 1'b1) press_seen++;
         check("bounce_press_pulse", 8'(press_pulse), 8'(i == 10));
         check("bounce_level",       8'(btn_level),   8'(i >= 10));
      end
      check("bounce_press_total", 8'(press_seen),  8'd1);
      check("bounce_count",       8'(press_count), 8'd2);
      btn_n_raw = 1'b1;
      watch(8, -1, 5, "bounce_release");

      // ---- Wrap: 9 clean pairs from a fresh reset -------------------------
      rst_n = 1'b0;
      tick();
      check_all_zero("reset3");
      rst_n      = 1'b1;
      press_seen = 0;
      rel_seen   = 0;
      for (int p = 0; p < 9; p++) begin
         btn_n_raw = 1'b0;
         watch(7, 5, -1, "wrap_press");
         check("wrap_count", 8'(press_count), 8'((p + 1) % 8));
         btn_n_raw = 1'b1;
         watch(7, -1, 5, "wrap_release");
      end
      check("wrap_press_total",   8'(press_seen),  8'd9);
      check("wrap_release_total", 8'(rel_seen),    8'd9);
      check("wrap_final_count",   8'(press_count), 8'd1);

      // ---- Reset in the middle of arming ---------------------------------
      btn_n_raw = 1'b0;
      watch(3, -1, -1, "mid_pre");
      rst_n = 1'b0;
      tick();
      check_all_zero("mid_reset");
      rst_n = 1'b1;
      watch(8, 5, -1, "mid_post");
      check("mid_count", 8'(press_count), 8'd1);
      check("mid_level", 8'(btn_level),   8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_button_debounce
`default_nettype wire
